// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data RAM between fetch and LDR/STR.
// Serialises IDLE/ACCESS/WAIT/RESP, hides RAM latency, guards fetch from starvation.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_rw_flag,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] LAT_INIT   = 3'(RAM_LAT);

    state_e            state_q;
    logic [2:0]        wait_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              sel_d_q;
    logic              fetch_win;
    logic              any_req;

    logic              if_gnt_q;
    logic              if_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_gnt_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              ram_en_q;
    logic              ram_rw_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_out_q;

    // Arbitration: data first unless fetch has lost STARVE_MAX times in a row
    always_comb begin
        any_req   = if_req | d_req;
        fetch_win = if_req & (~d_req | (starve_q == STARVE_LIM));
        starve_d  = starve_q;
        if (!if_req || fetch_win) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Access sequencer with registered strobes, latched request and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wait_q         <= 3'd0;
            starve_q       <= 4'd0;
            sel_d_q        <= 1'b0;
            if_gnt_q       <= 1'b0;
            if_valid_q     <= 1'b0;
            if_rdata_q     <= '0;
            d_gnt_q        <= 1'b0;
            d_valid_q      <= 1'b0;
            d_rdata_q      <= '0;
            ram_en_q       <= 1'b0;
            ram_rw_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_data_out_q <= '0;
        end else begin
            if_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            ram_en_q   <= 1'b0;
            unique case (state_q)
                S_IDLE, S_RESP: begin
                    starve_q <= starve_d;
                    if (any_req) begin
                        state_q  <= S_ACCESS;
                        sel_d_q  <= ~fetch_win;
                        ram_en_q <= 1'b1;
                        if_gnt_q <= fetch_win;
                        d_gnt_q  <= ~fetch_win;
                        if (fetch_win) begin
                            ram_addr_q <= if_addr;
                            ram_rw_q   <= 1'b1;
                        end else begin
                            ram_addr_q     <= d_addr;
                            ram_rw_q       <= ~d_we;
                            ram_data_out_q <= d_wdata;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    wait_q  <= LAT_INIT;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == 3'd1) begin
                        state_q <= S_RESP;
                        if (sel_d_q) begin
                            d_valid_q <= 1'b1;
                            if (ram_rw_q) begin
                                d_rdata_q <= ram_data_in;
                            end
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= ram_data_in;
                        end
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_gnt       = if_gnt_q;
    assign if_valid     = if_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_gnt        = d_gnt_q;
    assign d_valid      = d_valid_q;
    assign d_rdata      = d_rdata_q;
    assign ram_en       = ram_en_q;
    assign ram_rw_flag  = ram_rw_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_out = ram_data_out_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a RAM model and a transaction-level
// arbitration reference; two extra instances sweep RAM_LAT=1 and RAM_LAT=7.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int T    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          ram_en;
    logic          ram_rw_flag;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_out;
    logic [DW-1:0] ram_data_in = '0;
    logic          busy;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_rw_flag(ram_rw_flag), .ram_addr(ram_addr),
        .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        longint      t_acc;
    } exp_t;

    typedef struct {
        longint      due;
        logic [31:0] data;
    } rd_t;

    exp_t        exp_q[$];
    rd_t         rd_q[$];
    logic [31:0] ram_mem[64];
    logic [31:0] ref_mem[64];
    exp_t        dl[$];
    logic [15:0] fl[$];
    int          starve_m;

    // RAM model: read data valid only in the cycle RAM_LAT after ram_en
    rd_t    rm_r;
    longint rm_now;
    always @(negedge clk) begin
        rm_now = longint'($time);
        while (rd_q.size() > 0 && rd_q[0].due < rm_now) begin
            void'(rd_q.pop_front());
        end
        if (rd_q.size() > 0 && rd_q[0].due == rm_now) begin
            rm_r = rd_q.pop_front();
            ram_data_in = rm_r.data;
        end else begin
            ram_data_in = $urandom;
        end
        if (ram_en) begin
            if (ram_rw_flag) begin
                rm_r.due  = rm_now + LAT * T;
                rm_r.data = ram_mem[ram_addr[5:0]];
                rd_q.push_back(rm_r);
            end else begin
                ram_mem[ram_addr[5:0]] = ram_data_out;
            end
        end
    end

    // Monitor: pops the expected transaction at ram_en and retires it at valid
    bit          in_fl = 1'b0;
    exp_t        cur;
    longint      acc_t = 0;
    longint      last_vt = 0;
    longint      mn_now;
    logic [31:0] last_d = '0;
    logic [31:0] last_f = '0;
    always @(negedge clk) begin
        mn_now = longint'($time);
        if (!rst_n) begin
            in_fl  = 1'b0;
            last_d = '0;
            last_f = '0;
            chk("reset_outputs",
                {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, ram_en,
                 ram_rw_flag, ram_addr, ram_data_out, busy}, '0);
        end else begin
            chk("pulse_exclusive",
                {ram_en != (if_gnt | d_gnt), if_gnt & d_gnt, if_valid & d_valid}, '0);
            if (ram_en) begin
                if (in_fl || exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_access: addr %h, none expected", ram_addr);
                end else begin
                    cur   = exp_q.pop_front();
                    in_fl = 1'b1;
                    acc_t = mn_now;
                    chk("grant", {if_gnt, d_gnt, ram_rw_flag, ram_addr},
                        {cur.fetch, ~cur.fetch, ~cur.we, cur.addr});
                    if (cur.we) chk("write_data", ram_data_out, cur.wdata);
                    chk("access_time", mn_now,
                        (cur.t_acc < 0) ? last_vt + T : cur.t_acc);
                end
            end
            if (if_valid || d_valid) begin
                if (!in_fl) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: if %b d %b, none in flight",
                             if_valid, d_valid);
                end else begin
                    in_fl   = 1'b0;
                    last_vt = mn_now;
                    if (cur.fetch) last_f = cur.rdata;
                    else if (!cur.we) last_d = cur.rdata;
                    chk("valid", {if_valid, d_valid, if_rdata, d_rdata},
                        {cur.fetch, ~cur.fetch, last_f, last_d});
                    chk("valid_time", mn_now, acc_t + (LAT + 1) * T);
                end
            end
        end
    end

    task automatic wait_sig(input int which);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = d_gnt;
                1: hit = d_valid;
                2: hit = if_gnt;
                default: hit = if_valid;
            endcase
        end
        if (!hit) begin
            n_bad++;
            $display("FAIL timeout: handshake %0d never seen", which);
            summary();
            $fatal(1, "bench stopped on timeout");
        end
    endtask

    // Reference: service order from the arbitration rule, then drive both requesters
    task automatic run_scn();
        longint t0;
        int     i;
        int     j;
        bit     first;
        bit     pf;
        bit     pd;
        exp_t   e;
        i = 0;
        j = 0;
        first = 1'b1;
        @(negedge clk);
        t0 = longint'($time);
        while (i < dl.size() || j < fl.size()) begin
            pf = (j < fl.size());
            pd = (i < dl.size());
            if (pf && (!pd || starve_m == SMAX)) begin
                starve_m = 0;
                e.fetch = 1'b1;
                e.we    = 1'b0;
                e.addr  = fl[j];
                e.wdata = '0;
                e.rdata = ref_mem[e.addr[5:0]];
                j++;
            end else begin
                starve_m = pf ? ((starve_m == 15) ? 15 : starve_m + 1) : 0;
                e = dl[i];
                e.fetch = 1'b0;
                if (e.we) ref_mem[e.addr[5:0]] = e.wdata;
                else e.rdata = ref_mem[e.addr[5:0]];
                i++;
            end
            e.t_acc = first ? t0 + T : -1;
            first = 1'b0;
            exp_q.push_back(e);
        end
        fork
            begin
                for (int k = 0; k < dl.size(); k++) begin
                    d_req   = 1'b1;
                    d_we    = dl[k].we;
                    d_addr  = dl[k].addr;
                    d_wdata = dl[k].wdata;
                    wait_sig(0);
                    d_req   = 1'b0;
                    d_we    = 1'($urandom);
                    d_addr  = 16'($urandom);
                    d_wdata = $urandom;
                    wait_sig(1);
                end
            end
            begin
                for (int k = 0; k < fl.size(); k++) begin
                    if_req  = 1'b1;
                    if_addr = fl[k];
                    wait_sig(2);
                    if_req  = 1'b0;
                    if_addr = 16'($urandom);
                    wait_sig(3);
                end
            end
        join
        @(negedge clk);
        chk("drain", {busy, in_fl, exp_q.size() != 0}, '0);
    endtask

    function automatic exp_t mk(bit we, logic [15:0] a, logic [31:0] wd);
        exp_t e;
        e.fetch = 1'b0;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = '0;
        e.t_acc = 0;
        return e;
    endfunction

    // RAM_LAT sweep instances: valid exactly RAM_LAT+2 cycles after req
    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LL = (g == 0) ? 1 : 7;
        logic          l_rst_n = 1'b1;
        logic          l_if_req = 1'b0;
        logic [AW-1:0] l_if_addr = '0;
        logic          l_if_gnt;
        logic          l_if_valid;
        logic [DW-1:0] l_if_rdata;
        logic          l_d_req = 1'b0;
        logic          l_d_we = 1'b0;
        logic [AW-1:0] l_d_addr = '0;
        logic [DW-1:0] l_d_wdata = '0;
        logic          l_d_gnt;
        logic          l_d_valid;
        logic [DW-1:0] l_d_rdata;
        logic          l_ram_en;
        logic          l_ram_rw;
        logic [AW-1:0] l_ram_addr;
        logic [DW-1:0] l_ram_dout;
        logic [DW-1:0] l_ram_din = '0;
        logic          l_busy;
        bit            done = 1'b0;

        mem_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LL), .STARVE_MAX(SMAX)
        ) u_lane (
            .clk(clk), .rst_n(l_rst_n),
            .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt),
            .if_valid(l_if_valid), .if_rdata(l_if_rdata),
            .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
            .d_gnt(l_d_gnt), .d_valid(l_d_valid), .d_rdata(l_d_rdata),
            .ram_en(l_ram_en), .ram_rw_flag(l_ram_rw), .ram_addr(l_ram_addr),
            .ram_data_out(l_ram_dout), .ram_data_in(l_ram_din), .busy(l_busy)
        );

        initial begin
            logic [31:0] pat;
            bit          f;
            int          nv;
            #1 l_rst_n = 1'b0;
            repeat (2) @(negedge clk);
            #2 l_rst_n = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                f   = 1'($urandom_range(0, 1));
                pat = $urandom;
                nv  = 0;
                if (f) begin
                    l_if_req  = 1'b1;
                    l_if_addr = 16'($urandom);
                end else begin
                    l_d_req  = 1'b1;
                    l_d_we   = 1'b0;
                    l_d_addr = 16'($urandom);
                end
                for (int k = 1; k <= LL + 2; k++) begin
                    @(negedge clk);
                    l_ram_din = (k == LL + 1) ? pat : ~pat;
                    if (k == 1) begin
                        chk($sformatf("lat%0d_gnt", LL),
                            {f ? l_if_gnt : l_d_gnt, l_ram_en, l_ram_rw}, 3'b111);
                        l_if_req = 1'b0;
                        l_d_req  = 1'b0;
                    end
                    if (k < LL + 2 && (l_if_valid || l_d_valid)) nv++;
                end
                chk($sformatf("lat%0d_early_valid", LL), nv, 0);
                chk($sformatf("lat%0d_valid", LL),
                    {f ? l_if_valid : l_d_valid, f ? l_if_rdata : l_d_rdata},
                    {1'b1, pat});
            end
            done = 1'b1;
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "bench stopped by watchdog");
    end

    initial begin
        logic [31:0] v;
        exp_t        e;
        int          nd;
        int          nf;
        int          nv;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        ram_mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        starve_m = 0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                            ram_en, ram_addr, ram_data_out, busy}, '0);
        #2 rst_n = 1'b1;

        dl.delete(); fl.delete();
        dl.push_back(mk(1'b0, 16'h0010, 32'h0));
        run_scn();
        chk("ldr_deadbeef", d_rdata, 32'hDEADBEEF);

        dl.delete(); fl.delete();
        dl.push_back(mk(1'b1, 16'h0020, 32'h12345678));
        run_scn();
        chk("str_keeps_rdata", d_rdata, 32'hDEADBEEF);

        dl.delete(); fl.delete();
        dl.push_back(mk(1'b0, 16'h0020, 32'h0));
        fl.push_back(16'h0100);
        run_scn();
        chk("str_then_ldr", d_rdata, 32'h12345678);

        dl.delete(); fl.delete();
        for (int i = 0; i < 6; i++) dl.push_back(mk(1'(i % 2), 16'(i), $urandom));
        fl.push_back(16'h0207);
        run_scn();

        @(negedge clk);
        e = mk(1'b0, 16'h0031, 32'h0);
        e.t_acc = longint'($time) + T;
        exp_q.push_back(e);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0031;
        wait_sig(0);
        d_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                                ram_en, ram_rw_flag, ram_addr, ram_data_out, busy}, '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        starve_m = 0;
        nv = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (d_valid || if_valid) nv++;
        end
        chk("no_valid_after_reset", nv, 0);

        dl.delete(); fl.delete();
        dl.push_back(mk(1'b0, 16'h0010, 32'h0));
        run_scn();
        chk("ldr_after_reset", d_rdata, 32'hDEADBEEF);

        for (int s = 0; s < 40; s++) begin
            nd = $urandom_range(0, 6);
            nf = $urandom_range(0, 3);
            if (nd + nf == 0) nd = 1;
            dl.delete(); fl.delete();
            repeat (nd) begin
                dl.push_back(mk(1'($urandom_range(0, 1)),
                                16'($urandom) & 16'hC007, $urandom));
            end
            repeat (nf) fl.push_back(16'($urandom) & 16'hC007);
            run_scn();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int k = 0; k < 2000 && !(g_lane[0].done && g_lane[1].done); k++) begin
            @(negedge clk);
        end
        chk("lanes_done", {g_lane[0].done, g_lane[1].done}, 2'b11);

        summary();
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and sequencer for the single-port data RAM. It shares the RAM between the instruction-fetch requester and the data requester (LDR/STR from memory control). It serialises accesses through a grant/access/wait/response state machine, which hides the RAM read latency. A starvation guard stops a stream of back-to-back LDR/STR from permanently blocking fetch.

## Interface
- ADDR_W, 16, RAM address width; matches the 16-bit address bus.
- DATA_W, 32, data width.
- RAM_LAT, 2, cycles from the ram_en cycle to valid ram_data_in; legal range 1..7.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request (level); held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_valid  out  1  one-cycle pulse: if_rdata holds fetch data.
- if_rdata  out  DATA_W  fetch read data; held until the next fetch completes.
- d_req  in  1  data request (level); held with d_we, d_addr and d_wdata until d_gnt.
- d_we  in  1  1 = STR (write), 0 = LDR (read).
- d_addr  in  ADDR_W  data address (src1[15:0]).
- d_wdata  in  DATA_W  store data (src2).
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: LDR data ready or STR complete.
- d_rdata  out  DATA_W  LDR data; held until the next LDR completes; unchanged by STR.
- ram_en  out  1  RAM access strobe, one cycle per access.
- ram_rw_flag  out  1  1 = read, 0 = write; valid while ram_en = 1.
- ram_addr  out  ADDR_W  latched access address.
- ram_data_out  out  DATA_W  latched write data.
- ram_data_in  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any request is pending, arbitrate, latch the winner's address, rw and write data, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - ram_en = 1, ram_rw_flag = ~d_we for data accesses and 1 for fetch.
  - Pulse the winner's gnt.
  - Go to WAIT.
- WAIT (RAM_LAT cycles): a down-counter is loaded with RAM_LAT in ACCESS. In the last WAIT cycle:
  - For reads, register ram_data_in into the winner's rdata.
  - Go to RESP.
- RESP (1 cycle):
  - Pulse the winner's valid; writes also pulse d_valid.
  - Arbitrate exactly as in IDLE. A pending request goes straight to ACCESS; otherwise return to IDLE.
  - A req seen in RESP is a new request. Requesters drop req after gnt.
- Arbitration: d_req has priority over if_req, except when the starvation counter equals STARVE_MAX; then fetch wins.
- Starvation counter (4 bits, saturating):
  - Increments on each arbitration where if_req = 1 and data wins.
  - Clears when fetch is granted or when if_req = 0 at an arbitration point.
- The latched address and data are immune to input changes after the latch edge.
- Exactly one gnt and one valid are produced per access; if_* and d_* never pulse in the same cycle.

## Timing
- Reset (asynchronous, any state):
  - State returns to IDLE; counters clear.
  - All outputs go to 0, including rdata registers, ram_addr and ram_data_out.
  - An in-flight access is abandoned: no valid pulse; RAM data arriving later is ignored.
- Request seen in IDLE at cycle T:
  - ACCESS with gnt and ram_en at T+1.
  - WAIT from T+2 to T+1+RAM_LAT.
  - RESP with valid at T+2+RAM_LAT.
- Back-to-back throughput: one access per RAM_LAT+2 cycles.
- Simultaneous if_req and d_req: data wins unless the counter equals STARVE_MAX.
- A request that arrives while busy waits until the next RESP arbitration.

## Test plan
- Single LDR, RAM_LAT=2, d_addr=0x0010, RAM returns 0xDEADBEEF:
  - d_gnt and ram_en with ram_rw_flag=1 one cycle after d_req.
  - d_valid and d_rdata=0xDEADBEEF four cycles after d_req.
- Single STR, d_addr=0x0020, d_wdata=0x12345678:
  - ram_en with ram_rw_flag=0, ram_addr=0x0020, ram_data_out=0x12345678.
  - d_valid four cycles after d_req; d_rdata unchanged.
- Collision: d_req and if_req raised together:
  - Data served first.
  - Fetch's ACCESS begins in the cycle after data's RESP, with no IDLE cycle between.
- Starvation, STARVE_MAX=4: d_req re-asserted every RESP, if_req held high:
  - Exactly 4 data grants, then if_gnt; counter back to 0.
- Reset mid-WAIT during an LDR, released two cycles later:
  - All outputs 0 immediately; no d_valid.
  - A new request after release completes normally.
- RAM_LAT=1 and RAM_LAT=7 sweeps: valid exactly RAM_LAT+2 cycles after req in every case.
